// File: rtl/fp_csr_pkg.sv
// fp_csr_pkg: shared definitions for the floating-point CSR block.
//   - CSR addresses of fflags, frm and fcsr
//   - Zicsr operation encodings (csr_op_e)
//   - rounding-mode encodings (rm_e)
//   - fflags bit indices
//   - csr_apply(): the RW/RS/RC update rule shared by all three CSRs
package fp_csr_pkg;

  localparam logic [11:0] CSR_ADDR_FFLAGS = 12'h001;
  localparam logic [11:0] CSR_ADDR_FRM    = 12'h002;
  localparam logic [11:0] CSR_ADDR_FCSR   = 12'h003;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    DYN = 3'b111
  } rm_e;

  localparam int NV = 4;
  localparam int DZ = 3;
  localparam int OF = 2;
  localparam int UF = 1;
  localparam int NX = 0;

  // Field update for one CSR access. Callers pass fields narrower than
  // five bits zero-extended and keep only the low bits of the result.
  function automatic logic [4:0] csr_apply(input logic [1:0] op,
                                           input logic [4:0] old_v,
                                           input logic [4:0] w);
    logic [4:0] res;
    res = old_v;
    case (csr_op_e'(op))
      OP_RW:   res = w;
      OP_RS:   res = old_v | w;
      OP_RC:   res = old_v & ~w;
      default: res = old_v;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/fp_csr_if.sv
// fp_csr_if: Zicsr access bus between the core and the FP CSR block.
//   csr_en     CSR instruction retiring this cycle
//   csr_op     00 none, 01 RW, 10 RS, 11 RC
//   csr_addr   12-bit CSR address
//   csr_wdata  rs1 value or zero-extended immediate
//   csr_rdata  old value of the addressed CSR (combinational)
//   csr_hit    access targets one of the FP CSRs
// master: the core side. slave: the CSR block.
interface fp_csr_if;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit;

  modport master (
    output csr_en, csr_op, csr_addr, csr_wdata,
    input  csr_rdata, csr_hit
  );

  modport slave (
    input  csr_en, csr_op, csr_addr, csr_wdata,
    output csr_rdata, csr_hit
  );
endinterface

// File: rtl/fp_rm_resolve.sv
// fp_rm_resolve: combinational rounding-mode resolution.
//   instr_rm    rm field of the current FP instruction
//   frm_q       current dynamic rounding mode
//   rm_sel      resolved mode, select for the 8-to-1 rounding mux
//   rm_illegal  resolved mode is one of the reserved encodings
module fp_rm_resolve
  import fp_csr_pkg::*;
(
  input  logic [2:0] instr_rm,
  input  logic [2:0] frm_q,
  output logic [2:0] rm_sel,
  output logic       rm_illegal
);

  logic [2:0] eff;

  // DYN defers to frm; frm itself may hold a reserved value, so the
  // legality test is applied after substitution.
  assign eff        = (instr_rm == DYN) ? frm_q : instr_rm;
  assign rm_sel     = eff;
  assign rm_illegal = (eff == 3'b101) || (eff == 3'b110) || (eff == 3'b111);

endmodule

// File: rtl/fp_csr_unit.sv
// fp_csr_unit: fcsr register block for the RV32F core.
//   clk, rst     core clock; synchronous active-high reset
//   csr          fp_csr_if.slave Zicsr access bus (fflags, frm, fcsr)
//   fp_valid     FP arithmetic op retiring this cycle
//   fp_flags     {NV,DZ,OF,UF,NX} raised by that op, accumulated stickily
//   instr_rm     rm field of the current FP instruction
//   rm_sel       resolved rounding mode
//   rm_illegal   resolved rounding mode is reserved
//   frm_q        current frm register
//   fflags_q     current fflags register
module fp_csr_unit
  import fp_csr_pkg::*;
#(
  parameter logic [2:0]  RESET_FRM   = RNE,
  parameter logic [11:0] ADDR_FFLAGS = CSR_ADDR_FFLAGS,
  parameter logic [11:0] ADDR_FRM    = CSR_ADDR_FRM,
  parameter logic [11:0] ADDR_FCSR   = CSR_ADDR_FCSR
) (
  input  logic       clk,
  input  logic       rst,
  fp_csr_if.slave    csr,
  input  logic       fp_valid,
  input  logic [4:0] fp_flags,
  input  logic [2:0] instr_rm,
  output logic [2:0] rm_sel,
  output logic       rm_illegal,
  output logic [2:0] frm_q,
  output logic [4:0] fflags_q
);

  logic       hit_fflags;
  logic       hit_frm;
  logic       hit_fcsr;
  logic       csr_wr;
  logic [2:0] frm_d;
  logic [4:0] fflags_d;
  logic [4:0] frm_new;
  logic       unused_wdata;

  assign hit_fflags = csr.csr_en && (csr.csr_addr == ADDR_FFLAGS);
  assign hit_frm    = csr.csr_en && (csr.csr_addr == ADDR_FRM);
  assign hit_fcsr   = csr.csr_en && (csr.csr_addr == ADDR_FCSR);
  assign csr.csr_hit = hit_fflags || hit_frm || hit_fcsr;
  assign csr_wr     = csr.csr_hit && (csr.csr_op != OP_NONE);

  // Only the low byte of wdata can ever reach a field.
  assign unused_wdata = ^csr.csr_wdata[31:8];

  // Read data is the pre-write register value.
  always_comb begin
    csr.csr_rdata = 32'h0;
    if (hit_fflags)
      csr.csr_rdata = {27'b0, fflags_q};
    else if (hit_frm)
      csr.csr_rdata = {29'b0, frm_q};
    else if (hit_fcsr)
      csr.csr_rdata = {24'b0, frm_q, fflags_q};
  end

  // Next-state: an FPU flag update is overridden by a CSR write that
  // touches fflags (directly or through fcsr); an frm-only write leaves
  // accumulation alone.
  always_comb begin
    frm_new  = csr_apply(csr.csr_op, {2'b0, frm_q}, {2'b0, csr.csr_wdata[7:5]});
    frm_d    = frm_q;
    fflags_d = fflags_q;
    if (fp_valid)
      fflags_d = fflags_q | fp_flags;
    if (csr_wr && (hit_fflags || hit_fcsr))
      fflags_d = csr_apply(csr.csr_op, fflags_q, csr.csr_wdata[4:0]);
    if (csr_wr && hit_frm)
      frm_new = csr_apply(csr.csr_op, {2'b0, frm_q}, {2'b0, csr.csr_wdata[2:0]});
    if (csr_wr && (hit_frm || hit_fcsr))
      frm_d = frm_new[2:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frm_q    <= RESET_FRM;
      fflags_q <= 5'b0;
    end else begin
      frm_q    <= frm_d;
      fflags_q <= fflags_d;
    end
  end

  fp_rm_resolve u_rm_resolve (
    .instr_rm   (instr_rm),
    .frm_q      (frm_q),
    .rm_sel     (rm_sel),
    .rm_illegal (rm_illegal)
  );

endmodule

// File: tb/tb_fp_csr_unit.sv
// tb_fp_csr_unit: table-driven bench for fp_csr_unit. Combinational outputs
// are compared as each vector is applied; expected register state is queued
// and compared after the clock edge that should have produced it.
module tb_fp_csr_unit;
  import fp_csr_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       fp_valid;
  logic [4:0] fp_flags;
  logic [2:0] instr_rm;
  logic [2:0] rm_sel;
  logic       rm_illegal;
  logic [2:0] frm_q;
  logic [4:0] fflags_q;

  fp_csr_if bus ();

  fp_csr_unit dut (
    .clk        (clk),
    .rst        (rst),
    .csr        (bus),
    .fp_valid   (fp_valid),
    .fp_flags   (fp_flags),
    .instr_rm   (instr_rm),
    .rm_sel     (rm_sel),
    .rm_illegal (rm_illegal),
    .frm_q      (frm_q),
    .fflags_q   (fflags_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        fpv;
    logic [4:0]  flags;
    logic [2:0]  rm;
    logic [31:0] exp_rdata;
    logic        exp_hit;
    logic [2:0]  exp_sel;
    logic        exp_ill;
    logic [2:0]  exp_frm;
    logic [4:0]  exp_ff;
  } vec_t;

  typedef struct {
    logic [2:0] frm;
    logic [4:0] ff;
    string      tag;
  } exp_t;

  localparam int NVEC = 22;

  vec_t vecs [NVEC];
  exp_t sb [$];
  int   checks = 0;
  int   passed = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp)
      passed++;
    else
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  task automatic popCheck();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $display("[TB] FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = sb.pop_front();
      checkOutput({e.tag, "_frm"}, {29'b0, frm_q}, {29'b0, e.frm});
      checkOutput({e.tag, "_fflags"}, {27'b0, fflags_q}, {27'b0, e.ff});
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    rst           = v.rst;
    bus.csr_en    = v.en;
    bus.csr_op    = v.op;
    bus.csr_addr  = v.addr;
    bus.csr_wdata = v.wdata;
    fp_valid      = v.fpv;
    fp_flags      = v.flags;
    instr_rm      = v.rm;
    #1;
    checkOutput({tag, "_rdata"}, bus.csr_rdata, v.exp_rdata);
    checkOutput({tag, "_hit"}, {31'b0, bus.csr_hit}, {31'b0, v.exp_hit});
    checkOutput({tag, "_rm_sel"}, {29'b0, rm_sel}, {29'b0, v.exp_sel});
    checkOutput({tag, "_rm_illegal"}, {31'b0, rm_illegal}, {31'b0, v.exp_ill});
    e.frm = v.exp_frm;
    e.ff  = v.exp_ff;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    popCheck();
  endtask

  initial begin
    vec_t v;
    logic [4:0] acc;

    //                rst  en    op     addr     wdata        fpv   flags   rm      rdata        hit   sel     ill   frm     ff
    vecs[0]  = '{1'b0, 1'b1, 2'b00, 12'h003, 32'h0,        1'b0, 5'h00, 3'd7, 32'h00,      1'b1, 3'd0, 1'b0, 3'd0, 5'h00};
    vecs[1]  = '{1'b0, 1'b1, 2'b01, 12'h003, 32'hFFFFFF65, 1'b0, 5'h00, 3'd7, 32'h00,      1'b1, 3'd0, 1'b0, 3'd3, 5'h05};
    vecs[2]  = '{1'b0, 1'b1, 2'b00, 12'h003, 32'h0,        1'b0, 5'h00, 3'd7, 32'h65,      1'b1, 3'd3, 1'b0, 3'd3, 5'h05};
    vecs[3]  = '{1'b0, 1'b1, 2'b01, 12'h001, 32'h0,        1'b0, 5'h00, 3'd0, 32'h05,      1'b1, 3'd0, 1'b0, 3'd3, 5'h00};
    vecs[4]  = '{1'b0, 1'b0, 2'b00, 12'h000, 32'h0,        1'b1, 5'h01, 3'd0, 32'h00,      1'b0, 3'd0, 1'b0, 3'd3, 5'h01};
    vecs[5]  = '{1'b0, 1'b0, 2'b00, 12'h000, 32'h0,        1'b1, 5'h10, 3'd1, 32'h00,      1'b0, 3'd1, 1'b0, 3'd3, 5'h11};
    vecs[6]  = '{1'b0, 1'b1, 2'b11, 12'h001, 32'h01,       1'b0, 5'h00, 3'd2, 32'h11,      1'b1, 3'd2, 1'b0, 3'd3, 5'h10};
    vecs[7]  = '{1'b0, 1'b1, 2'b01, 12'h001, 32'h02,       1'b1, 5'h10, 3'd3, 32'h10,      1'b1, 3'd3, 1'b0, 3'd3, 5'h02};
    vecs[8]  = '{1'b0, 1'b1, 2'b01, 12'h002, 32'h01,       1'b1, 5'h04, 3'd4, 32'h03,      1'b1, 3'd4, 1'b0, 3'd1, 5'h06};
    vecs[9]  = '{1'b0, 1'b1, 2'b10, 12'h002, 32'hFFFFFFF6, 1'b0, 5'h00, 3'd7, 32'h01,      1'b1, 3'd1, 1'b0, 3'd7, 5'h06};
    vecs[10] = '{1'b0, 1'b1, 2'b00, 12'h002, 32'h0,        1'b0, 5'h00, 3'd7, 32'h07,      1'b1, 3'd7, 1'b1, 3'd7, 5'h06};
    vecs[11] = '{1'b0, 1'b0, 2'b00, 12'h000, 32'h0,        1'b0, 5'h00, 3'd6, 32'h00,      1'b0, 3'd6, 1'b1, 3'd7, 5'h06};
    vecs[12] = '{1'b0, 1'b0, 2'b00, 12'h000, 32'h0,        1'b0, 5'h00, 3'd4, 32'h00,      1'b0, 3'd4, 1'b0, 3'd7, 5'h06};
    vecs[13] = '{1'b0, 1'b0, 2'b00, 12'h000, 32'h0,        1'b0, 5'h00, 3'd5, 32'h00,      1'b0, 3'd5, 1'b1, 3'd7, 5'h06};
    vecs[14] = '{1'b0, 1'b1, 2'b11, 12'h003, 32'h000000A2, 1'b0, 5'h00, 3'd7, 32'hE6,      1'b1, 3'd7, 1'b1, 3'd2, 5'h04};
    vecs[15] = '{1'b0, 1'b1, 2'b10, 12'h001, 32'h0,        1'b0, 5'h00, 3'd7, 32'h04,      1'b1, 3'd2, 1'b0, 3'd2, 5'h04};
    vecs[16] = '{1'b0, 1'b1, 2'b01, 12'h300, 32'hFF,       1'b0, 5'h00, 3'd0, 32'h00,      1'b0, 3'd0, 1'b0, 3'd2, 5'h04};
    vecs[17] = '{1'b0, 1'b1, 2'b10, 12'h003, 32'h19,       1'b1, 5'h02, 3'd2, 32'h44,      1'b1, 3'd2, 1'b0, 3'd2, 5'h1D};
    vecs[18] = '{1'b0, 1'b1, 2'b00, 12'h003, 32'hFF,       1'b1, 5'h02, 3'd0, 32'h5D,      1'b1, 3'd0, 1'b0, 3'd2, 5'h1F};
    vecs[19] = '{1'b0, 1'b0, 2'b01, 12'h001, 32'h0,        1'b0, 5'h00, 3'd5, 32'h00,      1'b0, 3'd5, 1'b1, 3'd2, 5'h1F};
    vecs[20] = '{1'b1, 1'b1, 2'b01, 12'h003, 32'hFF,       1'b1, 5'h1F, 3'd7, 32'h5F,      1'b1, 3'd2, 1'b0, 3'd0, 5'h00};
    vecs[21] = '{1'b0, 1'b1, 2'b00, 12'h003, 32'h0,        1'b0, 5'h00, 3'd7, 32'h00,      1'b1, 3'd0, 1'b0, 3'd0, 5'h00};

    // Reset with an idle fcsr read on the bus.
    rst           = 1'b1;
    bus.csr_en    = 1'b1;
    bus.csr_op    = 2'b00;
    bus.csr_addr  = CSR_ADDR_FCSR;
    bus.csr_wdata = 32'h0;
    fp_valid      = 1'b0;
    fp_flags      = 5'h0;
    instr_rm      = 3'd7;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_frm", {29'b0, frm_q}, 32'h0);
    checkOutput("reset_fflags", {27'b0, fflags_q}, 32'h0);
    checkOutput("reset_rdata", bus.csr_rdata, 32'h0);
    checkOutput("reset_rm_sel", {29'b0, rm_sel}, 32'h0);
    checkOutput("reset_rm_illegal", {31'b0, rm_illegal}, 32'h0);

    for (int i = 0; i < NVEC; i++)
      applyStimulus(vecs[i], $sformatf("v%0d", i));

    // Back-to-back accumulation burst from a cleared fflags.
    acc = 5'h0;
    for (int i = 0; i < 8; i++) begin
      v.rst   = 1'b0;
      v.en    = 1'b0;
      v.op    = 2'b00;
      v.addr  = 12'h000;
      v.wdata = 32'h0;
      v.fpv   = 1'b1;
      v.flags = 5'($urandom_range(0, 31));
      v.rm    = 3'd7;
      v.exp_rdata = 32'h0;
      v.exp_hit   = 1'b0;
      v.exp_sel   = 3'd0;
      v.exp_ill   = 1'b0;
      acc = acc | v.flags;
      v.exp_frm = 3'd0;
      v.exp_ff  = acc;
      applyStimulus(v, $sformatf("burst%0d", i));
    end

    // RW frm then DYN the very next cycle must see the new value.
    v = '{1'b0, 1'b1, 2'b01, 12'h002, 32'h4, 1'b0, 5'h00, 3'd7, 32'h0, 1'b1, 3'd0, 1'b0, 3'd4, acc};
    applyStimulus(v, "frm_wr");
    v = '{1'b0, 1'b0, 2'b00, 12'h000, 32'h0, 1'b0, 5'h00, 3'd7, 32'h0, 1'b0, 3'd4, 1'b0, 3'd4, acc};
    applyStimulus(v, "frm_dyn");

    if (sb.size() != 0) begin
      checks++;
      $display("[TB] FAIL scoreboard_leftover actual=%0d required=0", sb.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fp_csr_unit.md
Name: fp_csr_unit

Overview:
- Floating-point control/status register block for the single-cycle RV32F core.
- Holds fcsr (frm[2:0] and fflags[4:0]) and executes Zicsr accesses to fflags, frm and fcsr.
- Accumulates sticky exception flags from the FPU on every retiring FP op.
- Resolves the instruction rm field against dynamic frm and drives the 3-bit rounding-mode select consumed by the downstream 8-to-1 rounding mux.

Parameters:
- RESET_FRM, 3'b000, frm value loaded on reset (RNE).
- ADDR_FFLAGS, 12'h001, CSR address of fflags.
- ADDR_FRM, 12'h002, CSR address of frm.
- ADDR_FCSR, 12'h003, CSR address of fcsr.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- csr_en  in  1  CSR instruction retiring this cycle.
- csr_op  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear).
- csr_addr  in  12  CSR address.
- csr_wdata  in  32  rs1 value or zero-extended immediate.
- csr_rdata  out  32  old value of the addressed CSR (combinational).
- csr_hit  out  1  csr_en is high and csr_addr matches one of the three addresses.
- fp_valid  in  1  FP arithmetic op retiring this cycle.
- fp_flags  in  5  {NV,DZ,OF,UF,NX} raised by that op.
- instr_rm  in  3  rm field of the current FP instruction.
- rm_sel  out  3  resolved rounding mode; drives the rounding mux select.
- rm_illegal  out  1  resolved rounding mode is reserved.
- frm_q  out  3  current frm register.
- fflags_q  out  5  current fflags register.

Behaviour:
- Reset (clk edge with rst=1): frm_q=RESET_FRM, fflags_q=0. All outputs are combinational from these registers and the inputs.
  - With instr_rm=0 after reset: rm_sel=000, rm_illegal=0.
- Reads (combinational, no latency; rdata always shows the pre-write value):
  - fflags: csr_rdata={27'b0,fflags_q}.
  - frm: csr_rdata={29'b0,frm_q}.
  - fcsr: csr_rdata={24'b0,frm_q,fflags_q}.
  - No hit: csr_rdata=0 and no register changes.
- Writes take effect on the next clk edge, only when csr_hit=1 and csr_op!=00. Let old be the addressed field and w the masked wdata:
  - fflags uses w=wdata[4:0].
  - frm uses w=wdata[2:0].
  - fcsr uses frm←wdata[7:5] and fflags←wdata[4:0] under the same op.
  - RW: new=w. RS: new=old|w. RC: new=old&~w.
  - wdata bits above the field are ignored.
  - An RS/RC with w=0 rewrites the unchanged value; there is no side effect.
- Flag accumulation: when fp_valid=1, fflags_q ← fflags_q | fp_flags on the next edge. Flags are sticky and cleared only by a CSR write or reset.
- Simultaneous CSR write to fflags or fcsr and fp_valid in one cycle: the CSR write wins and fp_flags is dropped.
- Simultaneous CSR write to frm only and fp_valid: both apply.
- rm resolution (combinational):
  - eff = (instr_rm==3'b111) ? frm_q : instr_rm.
  - rm_sel = eff.
  - rm_illegal = (eff==3'b101) | (eff==3'b110) | (eff==3'b111).
  - A dynamic rm with frm_q=111 is therefore illegal.
  - rm_illegal does not block writes or accumulation; trap handling is external.
- An frm write in cycle N affects rm_sel from cycle N+1.
- Reset asserted mid-stream overrides any same-cycle write or accumulation.

Decomposition:
- Package fp_csr_pkg holds:
  - CSR address localparams.
  - csr_op encodings: OP_NONE, OP_RW, OP_RS, OP_RC.
  - rm encodings: RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100, DYN=111.
  - flag bit indices NV=4, DZ=3, OF=2, UF=1, NX=0.
- One sub-module, fp_rm_resolve: purely combinational; instr_rm and frm_q in, rm_sel and rm_illegal out.

Test Plan:
- Reset, then read fcsr -> csr_rdata=0x00000000; with instr_rm=111: rm_sel=000, rm_illegal=0.
- RW fcsr wdata=0xFFFF_FF65 -> next cycle frm_q=011, fflags_q=00101; read fcsr returns 0x65; instr_rm=111 gives rm_sel=011.
- fp_valid with flags 00001, then 10000 on the next cycle -> fflags_q=10001. Then RC fflags wdata=0x01 -> fflags_q=10000.
- Same cycle: RW fflags wdata=0x02 and fp_valid flags=0x10 -> fflags_q=00010. Same cycle: RW frm=001 and fp_valid flags=0x04 -> frm_q=001 and the flag ORs in.
- RW frm wdata=0x7, instr_rm=111 -> rm_sel=111, rm_illegal=1; instr_rm=110 -> rm_illegal=1; instr_rm=100 -> rm_sel=100, rm_illegal=0.
- csr_addr=0x300 with RW 0xFF -> csr_hit=0, rdata=0, registers unchanged. rst asserted during a fcsr RW -> frm_q=RESET_FRM, fflags_q=0.
